// File: rtl/diff_patcher_pkg.sv
// Shared constants and state encoding for diff_patcher and its mask decoder.
// WIDTH-wide data, POS_W-wide positions; position value EQ_POS means "equal".
package diff_patcher_pkg;

  localparam int WIDTH = 32;
  localparam int POS_W = 6;
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [POS_W-1:0] EQ_POS  = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] TOG_MAX = POS_W'(63);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Saturating increment of the toggle counter.
  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] cnt);
    sat_inc = (cnt == TOG_MAX) ? cnt : cnt + POS_W'(1);
  endfunction

endpackage

// File: rtl/diff_mask_dec.sv
// One-hot decoder from a bit position to a WIDTH-wide toggle mask; zero for pos >= WIDTH.
// Combinational, no latency; no handshake.
// No backpressure.
module diff_mask_dec
  import diff_patcher_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] mask
);

  always_comb begin
    mask = '0;
    if (pos < EQ_POS) begin
      mask[pos[IDX_W-1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/diff_patcher.sv
// Rebuilds a word from a base plus a stream of bit positions to toggle.
// Latency: pos_ready one cycle after start; out_valid one cycle after the last position.
// Backpressure: pos_ready low outside ACCEPT; result held stable in DONE until out_ready.
module diff_patcher
  import diff_patcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] pos,
  input  logic             pos_last,
  output logic             pos_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [POS_W-1:0] toggles,
  output logic             err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [POS_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] toggle_mask;

  diff_mask_dec u_mask_dec (
    .pos  (pos),
    .mask (toggle_mask)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    err_d     = err_q;
    pos_ready = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = base;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        pos_ready = 1'b1;
        if (pos_valid) begin
          // The decoder yields an empty mask for the sentinel and out-of-range positions.
          acc_d = acc_q ^ toggle_mask;
          if (pos < EQ_POS) begin
            count_d = sat_inc(count_q);
          end
          if (pos > EQ_POS) begin
            err_d = 1'b1;
          end
          if (pos_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Result fields read as zero while idle so a stale word never leaks out.
  assign busy     = (state_q != ST_IDLE);
  assign out_data = busy ? acc_q   : '0;
  assign toggles  = busy ? count_q : '0;
  assign err      = busy ? err_q   : 1'b0;

endmodule
